modinv_2539: RTL and testbench



---
 rtl/modinv_2539.sv | 155 +++++++++++++++
 tb/tb_modinv_2539.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/modinv_2539.sv
// Modular inverse over GF(2539): a^(Q-2) mod Q by left-to-right
// square-and-multiply around a single Barrett-reduced multiplier.

module modinv_2539_modmul #(
  parameter int unsigned Q  = 2539,
  parameter int unsigned MU = 6607
) (
  input  logic [11:0] a_i,
  input  logic [11:0] b_i,
  output logic [11:0] r_o
);

  logic [23:0] p;
  logic [24:0] tm;
  logic [12:0] t;
  logic [23:0] tq;
  logic [13:0] r0;
  logic [13:0] r1;
  logic [13:0] r2;

  // quotient estimate undershoots by at most 2, so r0 < 3Q
  always_comb begin
    p  = 24'(a_i) * 24'(b_i);
    tm = 25'(p >> 12) * 25'(MU);
    t  = 13'(tm >> 12);
    tq = 24'(t) * 24'(Q);
    r0 = 14'(p - tq);
    r1 = (r0 >= 14'(Q)) ? r0 - 14'(Q) : r0;
    r2 = (r1 >= 14'(Q)) ? r1 - 14'(Q) : r1;
    r_o = 12'(r2);
  end

endmodule

module modinv_2539 #(
  parameter int unsigned Q   = 2539,
  parameter int unsigned MU  = 6607,
  parameter logic [11:0] EXP = 12'd2537
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] din_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] dout_r,
  output logic        dout_err
);

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] a_q, a_d;
  logic [11:0] acc_q, acc_d;
  logic [3:0]  idx_q, idx_d;
  logic        zero_q, zero_d;
  logic [11:0] dout_r_q, dout_r_d;
  logic        dout_err_q, dout_err_d;

  logic [11:0] din_red;
  logic [11:0] mul_b;
  logic [11:0] prod;

  assign din_red = (din_a >= 12'(Q)) ? din_a - 12'(Q) : din_a;
  assign mul_b   = (state_q == MUL) ? a_q : acc_q;

  modinv_2539_modmul #(
    .Q  (Q),
    .MU (MU)
  ) u_mm (
    .a_i (acc_q),
    .b_i (mul_b),
    .r_o (prod)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    zero_d     = zero_q;
    dout_r_d   = dout_r_q;
    dout_err_d = dout_err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = din_red;
          acc_d   = din_red;
          idx_d   = 4'd10;
          zero_d  = (din_red == 12'd0);
          state_d = SQR;
        end
      end
      SQR: begin
        acc_d = prod;
        if (EXP[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == 4'd0) begin
          state_d    = DONE;
          dout_r_d   = prod;
          dout_err_d = zero_q;
        end else begin
          idx_d = idx_q - 4'd1;
        end
      end
      MUL: begin
        acc_d = prod;
        if (idx_q == 4'd0) begin
          state_d    = DONE;
          dout_r_d   = prod;
          dout_err_d = zero_q;
        end else begin
          idx_d   = idx_q - 4'd1;
          state_d = SQR;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= 12'd0;
      acc_q      <= 12'd0;
      idx_q      <= 4'd10;
      zero_q     <= 1'b0;
      dout_r_q   <= 12'd0;
      dout_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      zero_q     <= zero_d;
      dout_r_q   <= dout_r_d;
      dout_err_q <= dout_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout_r    = dout_r_q;
  assign dout_err  = dout_err_q;

endmodule

// File: tb/tb_modinv_2539.sv
// Directed bench for modinv_2539: latency, handshake, reset,
// boundary operands, full inverse sweep and mod-mul reference.

module tb_modinv_2539;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] din_a = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] dout_r;
  logic        dout_err;

  logic [11:0] mm_a = 12'd0;
  logic [11:0] mm_b = 12'd0;
  logic [11:0] mm_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modinv_2539 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_r    (dout_r),
    .dout_err  (dout_err)
  );

  modinv_2539_modmul u_ref_mm (
    .a_i (mm_a),
    .b_i (mm_b),
    .r_o (mm_r)
  );

  task automatic run_op(
    input  logic [11:0] d,
    input  bit          take,
    output logic [11:0] r,
    output logic        e,
    output int          lat,
    output bit          to
  );
    int w;
    r = 12'd0; e = 1'b0; lat = 0; to = 1'b0; w = 0;
    while (!in_ready && w < 60) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin to = 1'b1; return; end
    din_a = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin to = 1'b1; return; end
    r = dout_r; e = dout_err;
    if (take) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (dout_r !== 12'd0 || dout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_dout got %0d/%b want 0/0", dout_r, dout_err);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unit();
    logic [11:0] r; logic e; int lat; bit to;
    run_op(12'd1, 1'b1, r, e, lat, to);
    checks++;
    if (to !== 1'b0) begin
      errors++; $display("FAIL unit_timeout got 1 want 0");
    end
    checks++;
    if (r !== 12'd1 || e !== 1'b0) begin
      errors++; $display("FAIL unit_result got %0d/%b want 1/0", r, e);
    end
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL unit_latency got %0d want 17", lat);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL unit_release got ov=%b ir=%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] r1, r2; bit got1, got2; int c, w;
    got1 = 1'b0; got2 = 1'b0; r1 = 12'd0; r2 = 12'd0; c = 0; w = 0;
    out_ready = 1'b1; din_a = 12'd2; in_valid = 1'b1;
    while (!in_ready && w < 60) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    din_a = 12'd3;
    while (c < 40) begin
      @(posedge clk); #1; c++;
      if (out_valid && !got1) begin r1 = dout_r; got1 = 1'b1; end
      if (in_ready) break;
    end
    @(posedge clk); c++; #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clk); #1; w++;
    end
    if (out_valid) begin r2 = dout_r; got2 = 1'b1; end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (!got1 || r1 !== 12'd1270) begin
      errors++; $display("FAIL b2b_first got %0d want 1270", r1);
    end
    checks++;
    if (c !== 19) begin
      errors++; $display("FAIL b2b_interval got %0d want 19", c);
    end
    checks++;
    if (!got2 || r2 !== 12'd1693) begin
      errors++; $display("FAIL b2b_second got %0d want 1693", r2);
    end
  endtask

  task automatic test_boundary();
    logic [11:0] din [4];
    logic [11:0] exp_r [4];
    logic        exp_e [4];
    logic [11:0] r; logic e; int lat; bit to;
    din[0] = 12'd2538; exp_r[0] = 12'd2538; exp_e[0] = 1'b0;
    din[1] = 12'd2540; exp_r[1] = 12'd1;    exp_e[1] = 1'b0;
    din[2] = 12'd0;    exp_r[2] = 12'd0;    exp_e[2] = 1'b1;
    din[3] = 12'd2541; exp_r[3] = 12'd1270; exp_e[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_op(din[i], 1'b1, r, e, lat, to);
      checks++;
      if (to || r !== exp_r[i] || e !== exp_e[i] || lat !== 17) begin
        errors++;
        $display("FAIL boundary_%0d got %0d/%b lat %0d want %0d/%b lat 17",
                 din[i], r, e, lat, exp_r[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] r; logic e; int lat; bit to;
    run_op(12'd3, 1'b0, r, e, lat, to);
    checks++;
    if (to || r !== 12'd1693) begin
      errors++; $display("FAIL bp_result got %0d want 1693", r);
    end
    din_a = 12'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout_r !== 12'd1693) begin
        errors++;
        $display("FAIL bp_hold_%0d got ov=%b ir=%b r=%0d want 1/0/1693",
                 i, out_valid, in_ready, dout_r);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_take got ov=%b ir=%b want 0/1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ignored got ir=%b want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] r; logic e; int lat; bit to;
    din_a = 12'd2000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        dout_r !== 12'd0 || dout_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset got ir=%b ov=%b r=%0d e=%b want 1/0/0/0",
               in_ready, out_valid, dout_r, dout_err);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(12'd2, 1'b1, r, e, lat, to);
    checks++;
    if (to || r !== 12'd1270 || e !== 1'b0 || lat !== 17) begin
      errors++;
      $display("FAIL midreset_next got %0d/%b lat %0d want 1270/0 lat 17",
               r, e, lat);
    end
  endtask

  task automatic test_sweep();
    logic [11:0] r; logic e; int lat; bit to;
    int prod;
    for (int a = 1; a < 2539; a++) begin
      run_op(12'(a), 1'b1, r, e, lat, to);
      prod = (a * int'(r)) % 2539;
      checks++;
      if (to || prod != 1 || e !== 1'b0 || lat !== 17) begin
        errors++;
        $display("FAIL sweep_%0d got r=%0d a*r=%0d e=%b want a*r=1 e=0",
                 a, r, prod, e);
      end
    end
  endtask

  task automatic test_modmul();
    int exp_v;
    for (int i = 0; i < 300; i++) begin
      if (i == 0) begin mm_a = 12'd2538; mm_b = 12'd2538; end
      else if (i == 1) begin mm_a = 12'd0; mm_b = 12'd2538; end
      else if (i == 2) begin mm_a = 12'd2537; mm_b = 12'd2538; end
      else begin
        mm_a = 12'($urandom_range(2538, 0));
        mm_b = 12'($urandom_range(2538, 0));
      end
      #1;
      exp_v = (int'(mm_a) * int'(mm_b)) % 2539;
      checks++;
      if (int'(mm_r) != exp_v) begin
        errors++;
        $display("FAIL modmul_%0dx%0d got %0d want %0d",
                 mm_a, mm_b, mm_r, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_back_to_back();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_modmul();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
